// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the 5-stage pipeline decode stage: opcodes,
//            ALU function codes, ALU operand-B selects and the control bundle.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes, IF/ID instruction[7:0]
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_SLL  = 8'h07;
    localparam logic [7:0] OP_SRA  = 8'h08;
    localparam logic [7:0] OP_SRL  = 8'h09;
    localparam logic [7:0] OP_ADDI = 8'h10;
    localparam logic [7:0] OP_LW   = 8'h20;
    localparam logic [7:0] OP_SW   = 8'h21;
    localparam logic [7:0] OP_J    = 8'h30;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    // ALU operand B select
    localparam logic [1:0] ALUSRC_DB    = 2'b00;
    localparam logic [1:0] ALUSRC_IMM   = 2'b01;
    localparam logic [1:0] ALUSRC_SHAMT = 2'b10;

    // Scoreboard depth: EX, MEM, WB
    localparam int SB_DEPTH = 3;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       jump;
        logic       pc_src;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // ALU function for the register/shift opcodes
    function automatic logic [3:0] f_alu_op(input logic [7:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_MUL:  return ALU_MUL;
            OP_XOR:  return ALU_XOR;
            OP_OR:   return ALU_OR;
            OP_AND:  return ALU_AND;
            OP_SLL:  return ALU_SLL;
            OP_SRA:  return ALU_SRA;
            OP_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : control_hazard_unit_if
// Brief    : IF/ID instruction fields in, decoded control bundle and hazard
//            status out. master = pipeline side, slave = control unit.
// Revision : 1.0 - initial release
// ============================================================================
interface control_hazard_unit_if;
    logic [7:0]  Op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        RegDst;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        RegWrite;
    logic        Jump;
    logic        PCSrc;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrc;
    logic        stall;
    logic        flush;
    logic        illegal;
    logic [15:0] stall_cnt;

    modport master (
        output Op, rs, rt, rd,
        input  RegDst, MemRead, MemWrite, MemToReg, RegWrite, Jump, PCSrc,
        input  ALUOp, ALUSrc, stall, flush, illegal, stall_cnt
    );

    modport slave (
        input  Op, rs, rt, rd,
        output RegDst, MemRead, MemWrite, MemToReg, RegWrite, Jump, PCSrc,
        output ALUOp, ALUSrc, stall, flush, illegal, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : 3-entry shift register of in-flight register writes (entry 0 =
//            EX, 1 = MEM, 2 = WB). Flags a hit when a valid entry matches a
//            source register the decoding instruction actually reads.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import cpu_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_push_valid,
    input  wire logic [4:0] i_push_rd,
    input  wire logic [4:0] i_rs,
    input  wire logic [4:0] i_rt,
    input  wire logic       i_use_rs,
    input  wire logic       i_use_rt,
    output logic            hit
);

    logic [SB_DEPTH-1:0]      r_valid;
    logic [SB_DEPTH-1:0][4:0] r_rd;
    logic [SB_DEPTH-1:0]      w_match;

    // Advance every entry one stage per clock; a stall does not freeze it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_rd    <= '0;
        end else begin
            r_valid <= {r_valid[SB_DEPTH-2:0], i_push_valid};
            r_rd    <= {r_rd[SB_DEPTH-2:0], i_push_rd};
        end
    end

    genvar g;
    for (g = 0; g < SB_DEPTH; g++) begin : g_match
        assign w_match[g] = r_valid[g] &&
                            ((i_use_rs && (r_rd[g] == i_rs)) ||
                             (i_use_rt && (r_rd[g] == i_rt)));
    end

    assign hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/control_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_hazard_unit
// Brief    : Decode-stage control and RAW hazard unit. Decodes the IF/ID
//            opcode into the datapath control bundle, stalls on hits in the
//            in-flight write scoreboard (no forwarding), squashes the slot
//            after a jump and counts stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module control_hazard_unit
    import cpu_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    control_hazard_unit_if.slave   bus
);

    ctrl_t       w_dec;
    ctrl_t       w_ctrl;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_legal;
    logic        w_live;
    logic        w_hit;
    logic        w_stall;
    logic        r_flush_pend;
    logic [15:0] r_stall_cnt;

    // Raw opcode decode, independent of stall/flush/reset
    always_comb begin
        w_dec    = CTRL_BUBBLE;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_legal  = 1'b1;
        case (bus.Op)
            OP_NOP: begin
            end
            OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_OR, OP_AND: begin
                w_dec.alu_op    = f_alu_op(bus.Op);
                w_dec.alu_src   = ALUSRC_DB;
                w_dec.reg_write = 1'b1;
                w_dec.reg_dst   = 1'b1;
                w_use_rs        = 1'b1;
                w_use_rt        = 1'b1;
            end
            OP_SLL, OP_SRA, OP_SRL: begin
                w_dec.alu_op    = f_alu_op(bus.Op);
                w_dec.alu_src   = ALUSRC_SHAMT;
                w_dec.reg_write = 1'b1;
                w_dec.reg_dst   = 1'b1;
                w_use_rs        = 1'b1;
            end
            OP_ADDI: begin
                w_dec.alu_op    = ALU_ADD;
                w_dec.alu_src   = ALUSRC_IMM;
                w_dec.reg_write = 1'b1;
                w_use_rs        = 1'b1;
            end
            OP_LW: begin
                w_dec.alu_op     = ALU_ADD;
                w_dec.alu_src    = ALUSRC_IMM;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_use_rs         = 1'b1;
            end
            OP_SW: begin
                w_dec.alu_op    = ALU_ADD;
                w_dec.alu_src   = ALUSRC_IMM;
                w_dec.mem_write = 1'b1;
                w_use_rs        = 1'b1;
                w_use_rt        = 1'b1;
            end
            OP_J: begin
                w_dec.jump   = 1'b1;
                w_dec.pc_src = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    hazard_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (w_ctrl.reg_write),
        .i_push_rd    (bus.rd),
        .i_rs         (bus.rs),
        .i_rt         (bus.rt),
        .i_use_rs     (w_use_rs),
        .i_use_rt     (w_use_rt),
        .hit          (w_hit)
    );

    // A slot is live when out of reset and not squashed by a preceding jump;
    // priority is reset > flush > stall > normal decode
    assign w_live  = reset && !r_flush_pend;
    assign w_stall = w_live && w_legal && w_hit;
    assign w_ctrl  = (w_live && !w_stall) ? w_dec : CTRL_BUBBLE;

    // Jump squash flag and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush_pend <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_flush_pend <= w_ctrl.jump;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.RegDst    = w_ctrl.reg_dst;
    assign bus.MemRead   = w_ctrl.mem_read;
    assign bus.MemWrite  = w_ctrl.mem_write;
    assign bus.MemToReg  = w_ctrl.mem_to_reg;
    assign bus.RegWrite  = w_ctrl.reg_write;
    assign bus.Jump      = w_ctrl.jump;
    assign bus.PCSrc     = w_ctrl.pc_src;
    assign bus.ALUOp     = w_ctrl.alu_op;
    assign bus.ALUSrc    = w_ctrl.alu_src;
    assign bus.stall     = w_stall;
    assign bus.flush     = reset && r_flush_pend;
    assign bus.illegal   = w_live && !w_legal;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
